// File: rtl/nano6502_bus_pkg.sv
// nano6502 bus decoder shared definitions.
// Holds the register offsets, the register window span, bank codes and the
// wait-state FSM state type. No ports.
package nano6502_bus_pkg;

  localparam logic [4:0] REG_IO_BANK_L = 5'h00;
  localparam logic [4:0] REG_IO_BANK_H = 5'h01;
  localparam logic [4:0] REG_ROM_SEL   = 5'h02;
  localparam logic [4:0] REG_STATUS    = 5'h03;
  localparam logic [4:0] REG_WP        = 5'h04;
  localparam logic [4:0] REG_WS_BASE   = 5'h10;

  // Register window covers 0x0000..0x001F.
  localparam int REG_SPAN = 32;

  // io_bank_l code 0 maps the I/O window onto ROM; codes 1.. pick a slot.
  localparam logic [7:0] BANK_ROM   = 8'd0;
  localparam logic [7:0] BANK_SLOT0 = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELEASE
  } wait_state_t;

endpackage

// File: rtl/bus_decoder_ws_wait.sv
// Wait-state / RDY generator for one I/O access at a time.
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   sel_valid          an I/O slot is currently selected
//   sel_slot           index of the selected slot
//   ws_sel, dev_rdy    wait-state count and device ready of the selected slot
//   flag_clr           software clear of the sticky timeout flag
//   rdy_o              CPU RDY (combinational in IDLE, 0 in WAIT, 1 in RELEASE)
//   timeout_pulse      one-cycle pulse when the watchdog forces a release
//   to_flag, to_slot   sticky timeout flag and the slot that timed out
//
// state      | meaning
// ST_IDLE    | no stall; a stalling slot access pulls rdy_o low at once
// ST_WAIT    | stalling the CPU, cnt counts stall cycles already spent
// ST_RELEASE | one cycle of rdy_o=1 so the CPU completes the access
module bus_wait_fsm
  import nano6502_bus_pkg::*;
#(
  parameter int WS_W           = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            sel_valid,
  input  logic [2:0]      sel_slot,
  input  logic [WS_W-1:0] ws_sel,
  input  logic            dev_rdy,
  input  logic            flag_clr,
  output logic            rdy_o,
  output logic            timeout_pulse,
  output logic            to_flag,
  output logic [2:0]      to_slot
);

  wait_state_t state;
  logic [7:0]  cnt;
  logic [2:0]  slot_q;
  logic        start;
  logic        left;
  logic        done;
  logic        tmo;
  logic [8:0]  cnt_inc;

  // Release is judged on the incremented count, so the IDLE cycle that
  // starts the stall counts as the first of the ws stall cycles.
  always_comb begin
    cnt_inc       = {1'b0, cnt} + 9'd1;
    start         = (state == ST_IDLE) && sel_valid && ((ws_sel != '0) || !dev_rdy);
    left          = !sel_valid || (sel_slot != slot_q);
    done          = (cnt_inc >= 9'(ws_sel)) && dev_rdy;
    tmo           = (cnt_inc == 9'(TIMEOUT_CYCLES));
    timeout_pulse = (state == ST_WAIT) && !left && !done && tmo;
    case (state)
      ST_IDLE:    rdy_o = !start;
      ST_RELEASE: rdy_o = 1'b1;
      default:    rdy_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      slot_q  <= '0;
      to_flag <= 1'b0;
      to_slot <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_WAIT;
            cnt    <= 8'd1;
            slot_q <= sel_slot;
          end
        end
        ST_WAIT: begin
          if (left)              state <= ST_IDLE;
          else if (done || tmo)  state <= ST_RELEASE;
          else                   cnt   <= cnt_inc[7:0];
        end
        default: state <= ST_IDLE;
      endcase
      // A timeout in the same cycle as a software clear keeps the flag set.
      if (timeout_pulse) begin
        to_flag <= 1'b1;
        to_slot <= slot_q;
      end else if (flag_clr) begin
        to_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_decoder_ws.sv
// nano6502 address decoder with zero-page control registers, banked I/O
// window, ROM overlay and per-slot wait-state RDY generation.
// Optional feature macro: ROM_WRITE_PROTECT_EN (adds wp register at 0x04).
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   R_W_n            CPU read(1)/write(0)
//   addr_i, data_i   CPU address and write data
//   data_o           register read data (0 when regs_cs=0)
//   regs_cs, ram_cs, rom_cs, io_cs   one-hot target selects
//   ram_we           RAM write enable
//   io_rdy_i         per-slot device ready
//   rdy_o            CPU RDY
module bus_decoder_ws
  import nano6502_bus_pkg::*;
#(
  parameter int          NUM_IO_SLOTS   = 4,
  parameter logic [15:0] IO_BASE        = 16'hFE00,
  parameter logic [15:0] ROM_BASE       = 16'hE000,
  parameter int          WS_W           = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    R_W_n,
  input  logic [15:0]             addr_i,
  input  logic [7:0]              data_i,
  output logic [7:0]              data_o,
  output logic                    regs_cs,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic                    rom_cs,
  output logic [NUM_IO_SLOTS-1:0] io_cs,
  input  logic [NUM_IO_SLOTS-1:0] io_rdy_i,
  output logic                    rdy_o
);

  logic [7:0]      io_bank_l;
  logic [7:0]      io_bank_h;
  logic [7:0]      rom_sel;
  logic [WS_W-1:0] ws [NUM_IO_SLOTS];
  logic            in_regs, in_io, in_rom, slot_hit;
  logic [2:0]      slot;
  logic [WS_W-1:0] ws_sel;
  logic            rdy_sel;
  logic            reg_we, status_clr, wp_block;
  logic            to_flag, timeout_pulse;
  logic [2:0]      to_slot;
  logic [4:0]      off;
  logic [7:0]      rd;

  assign off      = addr_i[4:0];
  assign in_regs  = addr_i < 16'(REG_SPAN);
  assign in_io    = addr_i[15:8] == IO_BASE[15:8];
  assign in_rom   = addr_i >= ROM_BASE;
  assign slot_hit = (io_bank_l != BANK_ROM) && (io_bank_l <= 8'(NUM_IO_SLOTS));
  assign slot     = 3'(io_bank_l - BANK_SLOT0);

  always_comb begin
    regs_cs = 1'b0;
    ram_cs  = 1'b0;
    rom_cs  = 1'b0;
    io_cs   = '0;
    if (in_regs) begin
      regs_cs = 1'b1;
    end else if (in_io) begin
      if (io_bank_l == BANK_ROM) rom_cs = 1'b1;
      else if (slot_hit)
        for (int i = 0; i < NUM_IO_SLOTS; i++) io_cs[i] = (slot == 3'(i));
      else ram_cs = 1'b1;
    end else if (in_rom && (rom_sel == 8'd0)) begin
      rom_cs = 1'b1;
    end else begin
      ram_cs = 1'b1;
    end
  end

  always_comb begin
    ws_sel  = '0;
    rdy_sel = 1'b1;
    for (int i = 0; i < NUM_IO_SLOTS; i++)
      if (io_cs[i]) begin
        ws_sel  = ws[i];
        rdy_sel = io_rdy_i[i];
      end
  end

  bus_wait_fsm #(
    .WS_W           (WS_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .sel_valid     (|io_cs),
    .sel_slot      (slot),
    .ws_sel        (ws_sel),
    .dev_rdy       (rdy_sel),
    .flag_clr      (status_clr),
    .rdy_o         (rdy_o),
    .timeout_pulse (timeout_pulse),
    .to_flag       (to_flag),
    .to_slot       (to_slot)
  );

  assign reg_we     = regs_cs && !R_W_n && rdy_o;
  assign status_clr = reg_we && (off == REG_STATUS) && data_i[7];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      io_bank_l <= '0;
      io_bank_h <= '0;
      rom_sel   <= '0;
      for (int i = 0; i < NUM_IO_SLOTS; i++) ws[i] <= '0;
    end else if (reg_we) begin
      case (off)
        REG_IO_BANK_L: io_bank_l <= data_i;
        REG_IO_BANK_H: io_bank_h <= data_i;
        REG_ROM_SEL:   rom_sel   <= data_i;
        default: ;
      endcase
      for (int i = 0; i < NUM_IO_SLOTS; i++)
        if (off == REG_WS_BASE + 5'(i)) ws[i] <= data_i[WS_W-1:0];
    end
  end

`ifdef ROM_WRITE_PROTECT_EN
  logic wp;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                         wp <= 1'b0;
    else if (reg_we && (off == REG_WP))   wp <= data_i[0];
  end
  // Protects a RAM-loaded OS image living under the ROM overlay range.
  assign wp_block = (rom_sel != 8'd0) && wp && in_rom;
`else
  assign wp_block = 1'b0;
`endif

  assign ram_we = ram_cs && !R_W_n && rdy_o && !wp_block;

  always_comb begin
    rd = 8'd0;
    case (off)
      REG_IO_BANK_L: rd = io_bank_l;
      REG_IO_BANK_H: rd = io_bank_h;
      REG_ROM_SEL:   rd = rom_sel;
      REG_STATUS:    rd = {to_flag, 4'b0000, to_slot};
`ifdef ROM_WRITE_PROTECT_EN
      REG_WP:        rd = {7'd0, wp};
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_IO_SLOTS; i++)
      if (off == REG_WS_BASE + 5'(i)) rd = 8'(ws[i]);
    data_o = regs_cs ? rd : 8'd0;
  end

endmodule
